// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES definitions for the key schedule and round datapath.
//   NUM_ROUNDS_DEF : AES-128 round count (round keys produced = rounds + 1)
//   ST_IDLE/ST_EXPAND : key-expansion FSM encoding
//   rcon_byte()    : round constant for round 1..10, MSB byte of the Rcon word
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  // Rcon table; index 0 and indices beyond 10 are unused and return 0.
  function automatic logic [7:0] rcon_byte(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox -- 8-bit combinational AES forward S-box (shared with SubBytes).
//   i_byte : input byte
//   o_byte : substituted byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Row r holds S(16r .. 16r+15); entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_msb;

  assign w_msb  = 11'd2047 - {i_byte, 3'b000};
  assign o_byte = SBOX[w_msb -: 8];

endmodule

// File: rtl/key_expansion.sv
// key_expansion -- AES-128 key schedule, one round key per accepted transfer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, key_in    : begin expansion of key_in (only taken when idle)
//   round_key_ready  : consumer accepts round_key this cycle
//   round_key_valid  : round_key / round_idx valid
//   round_key        : current round key (w0 in [127:96], byte 0 = MSB)
//   round_idx        : 0..NUM_ROUNDS
//   busy             : expansion in progress
//   done             : one-cycle pulse after the last key is accepted
module key_expansion
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         round_key_ready,
  output logic         round_key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [0:0]   r_state;
  logic [127:0] r_key;
  logic [3:0]   r_idx;
  logic         r_done;

  logic [31:0]  w_rot, w_sub, w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic         w_xfer;

  // RotWord of w3: byte a0 moves from the top to the bottom.
  assign w_rot = {r_key[23:0], r_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  // Next key is computed straight from the held key so it is ready one
  // cycle after every transfer without any extra pipeline state.
  assign w_temp = w_sub ^ {rcon_byte(r_idx + 4'd1), 24'h0};
  assign w_n0   = r_key[127:96] ^ w_temp;
  assign w_n1   = r_key[95:64]  ^ w_n0;
  assign w_n2   = r_key[63:32]  ^ w_n1;
  assign w_n3   = r_key[31:0]   ^ w_n2;

  assign w_xfer = (r_state == ST_EXPAND) && round_key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key   <= key_in;
            r_idx   <= '0;
            r_state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              // Key and index stay as last presented once idle.
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_key <= {w_n0, w_n1, w_n2, w_n3};
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign round_key_valid = (r_state == ST_EXPAND);
  assign busy            = (r_state != ST_IDLE);
  assign round_key       = r_key;
  assign round_idx       = r_idx;
  assign done            = r_done;

endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion -- scoreboard bench for key_expansion. Expected round keys
// come from a behavioural key schedule whose S-box is derived from GF(2^8)
// inversion plus the affine map, and are checked against FIPS-197 vectors.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n, start, round_key_ready;
  logic [127:0] key_in;
  logic         round_key_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  always #5 clk = ~clk;

  key_expansion dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .key_in          (key_in),
    .round_key_ready (round_key_ready),
    .round_key_valid (round_key_valid),
    .round_key       (round_key),
    .round_idx       (round_idx),
    .busy            (busy),
    .done            (done)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   sbx[256];
  logic [127:0] cap[11];
  int           total = 0, bad = 0;
  int           cyc = 0, done_cnt = 0, drv_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
  endfunction

  function automatic logic [127:0] nxt(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = subw({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic push_exp(input logic [127:0] key);
    logic [127:0] k  = key;
    logic [7:0]   rc = 8'h01;
    for (int i = 0; i <= 10; i++) begin
      sb_q.push_back('{idx: 4'(i), key: k});
      k  = nxt(k, rc);
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (rst_n && round_key_valid && round_key_ready) begin
      if (sb_q.size() == 0) chk("unexpected_key", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("rk", round_key, e.key);
        chk("idx", round_idx, e.idx);
        chk("busy_xfer", busy, 1);
        if (round_idx <= 4'd10) cap[round_idx] = round_key;
      end
    end
  end

  // Drive start for one cycle (from posedge+1) and check key 0 one cycle later.
  task automatic kick(input logic [127:0] key);
    drv_cyc = cyc;
    push_exp(key);
    start  = 1'b1;
    key_in = key;
    tick();
    start = 1'b0;
    chk("k0_valid", round_key_valid, 1);
    chk("k0_idx", round_idx, 0);
    chk("k0_key", round_key, key);
  endtask

  task automatic wait_done(input string tag, input int lat);
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (done) seen = 1;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_lat"}, cyc - drv_cyc, lat);
      chk({tag, "_valid_in_done"}, round_key_valid, 0);
      chk({tag, "_busy_in_done"}, busy, 0);
    end
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (round_key_valid && round_idx == idx) seen = 1;
    end
    if (!seen) chk("wait_idx_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbx[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    rst_n = 1'b0; start = 1'b0; key_in = '0; round_key_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", round_key_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", round_idx, 0);
    chk("rst_key", round_key, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // FIPS-197 vector, continuous ready.
    kick(FIPS_KEY);
    wait_done("fips", 12);
    chk("fips_k1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_k10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("done_pulse_len", done, 0);
    chk("fips_q_empty", sb_q.size(), 0);

    // All-zero key.
    kick('0);
    wait_done("zero", 12);
    chk("zero_k1", cap[1], 128'h62636363626363636263636362636363);
    chk("zero_k10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    tick();

    // Backpressure for three cycles while key 2 is presented.
    kick(FIPS_KEY);
    wait_idx(4'd2);
    round_key_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", round_key_valid, 1);
      chk("stall_idx", round_idx, 2);
      chk("stall_key", round_key, 128'hf2c295f27a96b9435935807a7359f67f);
    end
    round_key_ready = 1'b1;
    wait_done("stall", 15);
    tick();

    // start with another key mid-expansion is ignored.
    kick(FIPS_KEY);
    wait_idx(4'd5);
    start = 1'b1; key_in = ALT_KEY;
    tick();
    start = 1'b0;
    chk("intrude_busy", busy, 1);
    wait_done("intrude", 12);
    chk("intrude_k10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("intrude_q_empty", sb_q.size(), 0);

    // Reset at key 7 aborts with no done pulse.
    kick(FIPS_KEY);
    wait_idx(4'd7);
    n0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", round_key_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_idx", round_idx, 0);
    chk("abort_key", round_key, 0);
    sb_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, n0);
    chk("abort_idle", busy, 0);
    kick(ALT_KEY);
    wait_done("after_abort", 12);
    tick();

    // Back-to-back: new start in the done cycle.
    kick(FIPS_KEY);
    wait_done("b2b_first", 12);
    kick('0);
    wait_done("b2b_second", 12);
    chk("b2b_k1", cap[1], 128'h62636363626363636263636362636363);
    tick();
    chk("b2b_q_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10: AES-128 round count; round keys emitted = NUM_ROUNDS+1.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request expansion of key_in; sampled only in IDLE.
REQ-005 SHALL have port key_in  input  128  cipher key; bits [127:96] = w0, byte 0 = MSB.
REQ-006 SHALL have port round_key_ready  input  1  consumer (round datapath) accepts round_key.
REQ-007 SHALL have port round_key_valid  output  1  round_key and round_idx are valid.
REQ-008 SHALL have port round_key  output  128  current round key, same word/byte order as key_in.
REQ-009 SHALL have port round_idx  output  4  index of round_key, 0..NUM_ROUNDS.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final key is accepted.

Function
REQ-012 SHALL implement FSM states IDLE and EXPAND.
REQ-013 IDLE with start=1: SHALL register key_in and enter EXPAND; next cycle round_key=key_in, round_idx=0, round_key_valid=1 (1-cycle latency).
REQ-014 Transfer SHALL occur on a cycle where round_key_valid and round_key_ready are both 1.
REQ-015 With round_key_valid=1 and round_key_ready=0, round_key and round_idx SHALL hold stable; valid SHALL stay 1.
REQ-016 On transfer with round_idx<NUM_ROUNDS: next cycle SHALL present key round_idx+1 with valid=1, giving one key per cycle under continuous ready.
REQ-017 Next key from {w0,w1,w2,w3}: n0=w0^SubWord(RotWord(w3))^Rcon[i], n1=w1^n0, n2=w2^n1, n3=w3^n2; i=round_idx+1.
REQ-018 RotWord{a0,a1,a2,a3}={a1,a2,a3,a0}; SubWord SHALL apply the AES S-box to each byte.
REQ-019 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the MSB byte, other bytes 0.
REQ-020 On transfer with round_idx=NUM_ROUNDS: next cycle valid=0, done=1 for exactly one cycle, FSM to IDLE.
REQ-021 start while busy=1 SHALL be ignored, including the final-transfer cycle; key_in SHALL not be resampled.
REQ-022 start is sampled again in the cycle done=1 (FSM already IDLE); an accepted start there gives key 0 on the following cycle.
REQ-023 Outside EXPAND, round_key_valid SHALL be 0; round_key and round_idx retain their last values.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, round_key_valid=0, done=0, busy=0, round_idx=0, round_key=0.
REQ-025 Reset mid-expansion SHALL abort with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-026 Shared package aes_pkg SHALL hold the Rcon table, the NUM_ROUNDS default and the FSM state encoding.
REQ-027 SubWord SHALL use four instances of sub-module aes_sbox (8-bit combinational S-box), shared with the SubBytes datapath.
REQ-028 Next-key logic SHALL be combinational from the round_key register; no multi-cycle paths.

Verification
REQ-029 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 -> valid 11 consecutive cycles, idx 0..10; idx1 a0fafe1788542cb123a339392a6c7605; idx10 d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle later.
REQ-030 All-zero key, ready=1 -> idx1 62636363626363636263636362636363; idx10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 Same FIPS key, ready=0 for 3 cycles while idx=2 -> round_key and idx=2 stable, valid=1; completion 3 cycles later than in REQ-029.
REQ-032 start with a different key_in at idx=5 -> ignored; remaining keys match the original key; busy=1 throughout.
REQ-033 rst_n low at idx=7 -> outputs zero immediately; no done pulse; new start after release gives idx0=new key one cycle later.
REQ-034 start asserted in the done cycle -> idx0 of the new key on the next cycle; no lost or duplicated key.
